daq_cfg_rx: RTL and testbench
=============================

# daq_cfg_rx

Host-to-FPGA command receiver for the DAQ path: it pops 32-bit words written by the host through the Xillybus write_32 stream and parses them into framed configuration commands. Frames have a header, an optional payload, and a tailer with a checksum. Payload words go into a 16-entry buffer and are committed to the configuration register port only after the tailer checks good. It is the inbound counterpart of the test-data generator that feeds read_32, and replaces the single-byte mem_8 start/reset/close flag compare.

## Interface
- MAX_LEN, 16: maximum payload words per frame; sets buffer depth.
- bus_clk  in  1  Xillybus bus clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- host_open  in  1  user_w_write_32_open; low aborts parsing.
- fifo_dout  in  32  FWFT FIFO head word; valid while fifo_empty is low.
- fifo_empty  in  1  FIFO empty.
- fifo_rd_en  out  1  pops the head word in the same cycle; combinational.
- cfg_wr_en  out  1  configuration register write strobe.
- cfg_addr  out  8  configuration register address.
- cfg_wr_data  out  32  configuration register data.
- daq_start, daq_reset, daq_close  out  1 each  one-cycle command pulses.
- busy  out  1  high whenever the state is not HUNT.
- frame_ok_cnt, frame_err_cnt  out  16 each  saturating counters.
- hdr_err_cnt  out  16  saturating count of discarded non-header words.

## Operation
Frame format:
- Header: [31:24]=0xF0, [23:16]=CMD, [15:8]=LEN, [7:0]=BASE.
- Payload: LEN words.
- Tailer: [31:24]=0xAA, [23:0]=CHK.
- CHK = bits [23:0] of the 32-bit XOR of the header and all payload words.

Commands:
- 0x01 WRITE_REGS: LEN is 0..MAX_LEN.
- 0x02 START, 0x03 RESET, 0x04 CLOSE: LEN must be 0.

States:
- HUNT: on a popped word, if [31:24]==0xF0 and LEN<=MAX_LEN, latch CMD/LEN/BASE, set xor=word, set idx=0, and go to PAYLOAD (or TAIL if LEN=0). Otherwise discard the word and increment hdr_err_cnt.
- PAYLOAD: store each popped word in buf[idx], XOR it into xor, increment idx. After the LEN-th word go to TAIL.
- TAIL: pop one word. The frame is good if [31:24]==0xAA, [23:0]==xor[23:0], CMD is in 0x01..0x04, and (CMD==0x01 or LEN==0).
  - Good frame: increment frame_ok_cnt and go to COMMIT.
  - Bad frame: increment frame_err_cnt, discard the buffer, return to HUNT.
- COMMIT, CMD 0x01: write buf[i] to address BASE+i (8-bit wrap) for i=0..LEN-1, one write per cycle, then go to HUNT. LEN=0 goes directly to HUNT.
- COMMIT, CMD 0x02/0x03/0x04: pulse the matching daq_* output for one cycle, then go to HUNT.

Popping:
- fifo_rd_en = !fifo_empty && host_open && state in {HUNT, PAYLOAD, TAIL}.
- fifo_rd_en is never asserted in COMMIT.

Abort and counters:
- host_open low: synchronous return to HUNT and the partial frame is dropped. Counters are not reset and no frame_err_cnt increment occurs.
- Counters stick at 0xFFFF.

## Timing
- Reset values: all outputs 0, state HUNT, counters 0, buffer contents don't-care.
- One word is consumed per cycle with no bubbles between header, payload and tailer.
- Tailer popped at cycle T:
  - Writes appear at T+1 .. T+LEN.
  - Pulses appear at T+1.
  - Back in HUNT at T+LEN+1 (T+1 if LEN=0); popping may resume in that cycle.
- cfg_wr_en, cfg_addr, cfg_wr_data, daq_* and busy are registered outputs.
- Counter increments become visible the cycle after the deciding pop.
- fifo_empty mid-frame stalls the parser with state held. There is no timeout.
- reset_n low mid-COMMIT stops writes immediately; no partial pulse is generated.

## Test plan
- Write frame: header 0xF0010210, payloads 0x11111111 and 0x22222222, tailer 0xAA323123 -> writes (0x10, 0x11111111) and (0x11, 0x22222222) on consecutive cycles; frame_ok_cnt=1.
- Start: header 0xF0020000, tailer 0xAA020000 -> a single one-cycle daq_start pulse at T+1; no cfg_wr_en. Repeat with CMD 0x03 and 0x04 for daq_reset and daq_close.
- Bad checksum: the write frame above with tailer 0xAA323124 -> no writes, frame_err_cnt=1. A following good frame commits normally.
- Garbage then frame: 0x12345678, 0xDEADBEEF, then a valid start frame -> hdr_err_cnt=2, daq_start pulses.
- Address wrap and abort: header 0xF00103FE with 3 payloads -> addresses 0xFE, 0xFF, 0x00. Separately, drop host_open after header plus 1 payload -> no writes, busy=0 next cycle.
- Stall: assert fifo_empty randomly during a LEN=16 frame -> all 16 writes in order with correct data. LEN=17 header -> hdr_err_cnt increments.

Source files
------------

// File: rtl/daq_cfg_rx.sv
// daq_cfg_rx
// Pops 32-bit host command words from the write_32 FWFT FIFO and parses them
// into framed configuration commands. A frame is a header, up to MAX_LEN
// payload words and a tailer carrying a checksum. Payload words are held in a
// local buffer and written out to the configuration register port only after
// the tailer checks good.
//
// Ports
//   bus_clk, reset_n          clock (rising edge) and async active-low reset
//   host_open                 write_32 stream open; low aborts the frame
//   fifo_dout, fifo_empty     FWFT FIFO head word and empty flag
//   fifo_rd_en                combinational pop of the head word
//   cfg_wr_en/addr/wr_data    registered configuration register write port
//   daq_start/reset/close     registered one-cycle command pulses
//   busy                      registered, high while the parser is not in HUNT
//   frame_ok_cnt              saturating count of good frames
//   frame_err_cnt             saturating count of frames with a bad tailer
//   hdr_err_cnt               saturating count of discarded non-header words
//
// state   | meaning
// HUNT    | waiting for a header word; non-headers are counted and dropped
// PAYLOAD | storing payload words into the buffer and folding the checksum
// TAIL    | checking the tailer; pulses / first write are issued from here
// COMMIT  | draining the remaining buffered writes, one per cycle
module daq_cfg_rx #(
  parameter int MAX_LEN = 16
) (
  input  logic        bus_clk,
  input  logic        reset_n,
  input  logic        host_open,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        cfg_wr_en,
  output logic [7:0]  cfg_addr,
  output logic [31:0] cfg_wr_data,
  output logic        daq_start,
  output logic        daq_reset,
  output logic        daq_close,
  output logic        busy,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_err_cnt,
  output logic [15:0] hdr_err_cnt
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_TAIL    = 2'd2;
  localparam logic [1:0] ST_COMMIT  = 2'd3;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_START = 8'h02;
  localparam logic [7:0] CMD_RESET = 8'h03;
  localparam logic [7:0] CMD_CLOSE = 8'h04;

  logic [1:0]    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    base_q, base_d;
  logic [23:0]   xor_q, xor_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    idx_ext;

  logic          cfg_wr_en_q, cfg_wr_en_d;
  logic [7:0]    cfg_addr_q, cfg_addr_d;
  logic [31:0]   cfg_wr_data_q, cfg_wr_data_d;
  logic          daq_start_q, daq_start_d;
  logic          daq_reset_q, daq_reset_d;
  logic          daq_close_q, daq_close_d;
  logic          busy_q, busy_d;
  logic [15:0]   ok_cnt_q, ok_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
  logic [15:0]   hdr_cnt_q, hdr_cnt_d;

  logic [31:0]   buf_q [MAX_LEN];
  logic          buf_we;

  logic          is_header;
  logic          tail_good;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign idx_ext = 8'(idx_q);

  assign fifo_rd_en = !fifo_empty && host_open && (state_q != ST_COMMIT);

  assign is_header = (fifo_dout[31:24] == 8'hF0) && (fifo_dout[15:8] <= MAX_LEN_B);

  // The checksum covers only the low 24 bits, so only those are accumulated.
  assign tail_good = (fifo_dout[31:24] == 8'hAA) &&
                     (fifo_dout[23:0] == xor_q) &&
                     (cmd_q >= CMD_WRITE) && (cmd_q <= CMD_CLOSE) &&
                     ((cmd_q == CMD_WRITE) || (len_q == 8'd0));

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    base_d        = base_q;
    xor_d         = xor_q;
    idx_d         = idx_q;
    buf_we        = 1'b0;
    cfg_wr_en_d   = 1'b0;
    cfg_addr_d    = cfg_addr_q;
    cfg_wr_data_d = cfg_wr_data_q;
    daq_start_d   = 1'b0;
    daq_reset_d   = 1'b0;
    daq_close_d   = 1'b0;
    ok_cnt_d      = ok_cnt_q;
    err_cnt_d     = err_cnt_q;
    hdr_cnt_d     = hdr_cnt_q;

    if (!host_open) begin
      // Host closed the stream: drop whatever was in flight, no error count.
      state_d = ST_HUNT;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (fifo_rd_en) begin
            if (is_header) begin
              cmd_d   = fifo_dout[23:16];
              len_d   = fifo_dout[15:8];
              base_d  = fifo_dout[7:0];
              xor_d   = fifo_dout[23:0];
              idx_d   = '0;
              state_d = (fifo_dout[15:8] == 8'd0) ? ST_TAIL : ST_PAYLOAD;
            end else begin
              hdr_cnt_d = sat_inc(hdr_cnt_q);
            end
          end
        end

        ST_PAYLOAD: begin
          if (fifo_rd_en) begin
            buf_we = 1'b1;
            xor_d  = xor_q ^ fifo_dout[23:0];
            idx_d  = idx_q + IW'(1);
            if ((idx_ext + 8'd1) == len_q) begin
              state_d = ST_TAIL;
            end
          end
        end

        ST_TAIL: begin
          if (fifo_rd_en) begin
            state_d = ST_HUNT;
            if (tail_good) begin
              ok_cnt_d = sat_inc(ok_cnt_q);
              case (cmd_q)
                CMD_WRITE: begin
                  // First write leaves with the tailer so the writes land at
                  // T+1..T+LEN; COMMIT only drains the rest.
                  if (len_q != 8'd0) begin
                    cfg_wr_en_d   = 1'b1;
                    cfg_addr_d    = base_q;
                    cfg_wr_data_d = buf_q[0];
                    idx_d         = IW'(1);
                    state_d       = ST_COMMIT;
                  end
                end
                CMD_START: daq_start_d = 1'b1;
                CMD_RESET: daq_reset_d = 1'b1;
                CMD_CLOSE: daq_close_d = 1'b1;
                default: ;
              endcase
            end else begin
              err_cnt_d = sat_inc(err_cnt_q);
            end
          end
        end

        ST_COMMIT: begin
          if (idx_ext < len_q) begin
            cfg_wr_en_d   = 1'b1;
            cfg_addr_d    = base_q + idx_ext;
            cfg_wr_data_d = buf_q[idx_q[BW-1:0]];
            idx_d         = idx_q + IW'(1);
          end else begin
            state_d = ST_HUNT;
          end
        end

        default: state_d = ST_HUNT;
      endcase
    end

    busy_d = (state_d != ST_HUNT);
  end

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_HUNT;
      cmd_q         <= '0;
      len_q         <= '0;
      base_q        <= '0;
      xor_q         <= '0;
      idx_q         <= '0;
      cfg_wr_en_q   <= 1'b0;
      cfg_addr_q    <= '0;
      cfg_wr_data_q <= '0;
      daq_start_q   <= 1'b0;
      daq_reset_q   <= 1'b0;
      daq_close_q   <= 1'b0;
      busy_q        <= 1'b0;
      ok_cnt_q      <= '0;
      err_cnt_q     <= '0;
      hdr_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      base_q        <= base_d;
      xor_q         <= xor_d;
      idx_q         <= idx_d;
      cfg_wr_en_q   <= cfg_wr_en_d;
      cfg_addr_q    <= cfg_addr_d;
      cfg_wr_data_q <= cfg_wr_data_d;
      daq_start_q   <= daq_start_d;
      daq_reset_q   <= daq_reset_d;
      daq_close_q   <= daq_close_d;
      busy_q        <= busy_d;
      ok_cnt_q      <= ok_cnt_d;
      err_cnt_q     <= err_cnt_d;
      hdr_cnt_q     <= hdr_cnt_d;
    end
  end

  // Payload buffer needs no reset: entries are always written before read.
  always_ff @(posedge bus_clk) begin
    if (buf_we) begin
      buf_q[idx_q[BW-1:0]] <= fifo_dout;
    end
  end

  assign cfg_wr_en     = cfg_wr_en_q;
  assign cfg_addr      = cfg_addr_q;
  assign cfg_wr_data   = cfg_wr_data_q;
  assign daq_start     = daq_start_q;
  assign daq_reset     = daq_reset_q;
  assign daq_close     = daq_close_q;
  assign busy          = busy_q;
  assign frame_ok_cnt  = ok_cnt_q;
  assign frame_err_cnt = err_cnt_q;
  assign hdr_err_cnt   = hdr_cnt_q;

endmodule

// File: tb/tb_daq_cfg_rx.sv
// Testbench for daq_cfg_rx: FIFO model driven from a word queue, a
// frame-level reference model that predicts writes/pulses and counters, and a
// monitor that pops predictions whenever the DUT presents an output.
module tb_daq_cfg_rx;
  localparam int MAX_LEN = 16;

  logic        bus_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_open = 1'b0;
  logic [31:0] fifo_dout = 32'h0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic        cfg_wr_en;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_wr_data;
  logic        daq_start, daq_reset, daq_close, busy;
  logic [15:0] frame_ok_cnt, frame_err_cnt, hdr_err_cnt;

  daq_cfg_rx #(.MAX_LEN(MAX_LEN)) dut (
    .bus_clk(bus_clk), .reset_n(reset_n), .host_open(host_open),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data),
    .daq_start(daq_start), .daq_reset(daq_reset), .daq_close(daq_close),
    .busy(busy), .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt),
    .hdr_err_cnt(hdr_err_cnt)
  );

  always #5 bus_clk = ~bus_clk;

  // kind: 0 write, 1 start, 2 reset, 3 close
  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
    int          tail_idx;
    int          offs;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fq[$];
  logic [31:0] bq[$];
  int          pop_cyc[int];
  int          pop_idx = 0;
  int          g_idx = 0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          stall_pct = 0;
  int          m_ok = 0, m_err = 0, m_hdr = 0;

  always @(posedge bus_clk) cyc <= cyc + 1;

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask

  // Reference model: walks a batch of complete frames / garbage words.
  task automatic model_batch(input int base);
    int i, len;
    logic [7:0] cmd, ba;
    logic [31:0] w, t, x;
    bit good;
    exp_t e;
    i = 0;
    while (i < bq.size()) begin
      w = bq[i];
      if (w[31:24] != 8'hF0 || int'(w[15:8]) > MAX_LEN) begin
        m_hdr = sat(m_hdr);
        i++;
      end else begin
        cmd = w[23:16];
        len = int'(w[15:8]);
        ba  = w[7:0];
        x   = w;
        for (int k = 1; k <= len; k++) x ^= bq[i+k];
        t = bq[i+len+1];
        good = (t[31:24] == 8'hAA) && (t[23:0] == x[23:0]) &&
               (cmd >= 8'd1) && (cmd <= 8'd4) && (cmd == 8'd1 || len == 0);
        if (good) begin
          m_ok = sat(m_ok);
          if (cmd == 8'd1) begin
            for (int k = 0; k < len; k++) begin
              e.kind = 0; e.addr = ba + 8'(k); e.data = bq[i+1+k];
              e.tail_idx = base + i + len + 1; e.offs = k;
              exp_q.push_back(e);
            end
          end else begin
            e.kind = int'(cmd) - 1; e.addr = 8'h0; e.data = 32'h0;
            e.tail_idx = base + i + len + 1; e.offs = 0;
            exp_q.push_back(e);
          end
        end else begin
          m_err = sat(m_err);
        end
        i += len + 2;
      end
    end
  endtask

  task automatic add_frame(input logic [7:0] cmd, input logic [7:0] len,
                           input logic [7:0] base, input bit corrupt);
    logic [31:0] h, x, p, t;
    h = {8'hF0, cmd, len, base};
    bq.push_back(h);
    x = h;
    for (int k = 0; k < int'(len); k++) begin
      p = $urandom;
      bq.push_back(p);
      x ^= p;
    end
    t = {8'hAA, x[23:0]};
    if (corrupt) t ^= (32'h1 << $urandom_range(0, 31));
    bq.push_back(t);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge bus_clk);
      n++;
    end
    repeat (3) @(negedge bus_clk);
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s drain_timeout fifo_left=%0d exp_left=%0d required=0", tag, fq.size(), exp_q.size());
    end
    chk({tag, "_ok_cnt"}, {16'h0, frame_ok_cnt}, m_ok);
    chk({tag, "_err_cnt"}, {16'h0, frame_err_cnt}, m_err);
    chk({tag, "_hdr_cnt"}, {16'h0, hdr_err_cnt}, m_hdr);
  endtask

  task automatic send(input int sp, input string tag);
    stall_pct = sp;
    model_batch(g_idx);
    g_idx += bq.size();
    foreach (bq[k]) fq.push_back(bq[k]);
    bq.delete();
    wait_idle(tag);
  endtask

  task automatic sb_check(input int kind, input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    int tc;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output kind=%0d addr=%h data=%h required=none", kind, a, d);
      return;
    end
    e = exp_q.pop_front();
    tc = pop_cyc.exists(e.tail_idx) ? pop_cyc[e.tail_idx] + 1 + e.offs : -1;
    if (kind != e.kind || a !== e.addr || d !== e.data || cyc != tc) begin
      errors++;
      $display("FAIL scoreboard kind=%0d addr=%h data=%h cyc=%0d required kind=%0d addr=%h data=%h cyc=%0d",
               kind, a, d, cyc, e.kind, e.addr, e.data, tc);
    end
  endtask

  // FIFO driver: inputs change on the falling edge, pop decided just before
  // the rising edge that consumes the word.
  initial begin
    forever begin
      @(negedge bus_clk);
      fifo_empty = (fq.size() == 0) || ($urandom_range(0, 99) < stall_pct);
      fifo_dout  = (fq.size() != 0) ? fq[0] : $urandom;
      #4;
      if (fifo_rd_en && reset_n) begin
        if (fifo_empty) begin
          checks++;
          errors++;
          $display("FAIL rd_en_while_empty actual=1 required=0");
        end else begin
          pop_cyc[pop_idx] = cyc;
          pop_idx++;
          void'(fq.pop_front());
        end
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge bus_clk);
      if (reset_n) begin
        if (cfg_wr_en) sb_check(0, cfg_addr, cfg_wr_data);
        if (daq_start) sb_check(1, 8'h0, 32'h0);
        if (daq_reset) sb_check(2, 8'h0, 32'h0);
        if (daq_close) sb_check(3, 8'h0, 32'h0);
      end
    end
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int n, nitems, sel, c;
    logic [31:0] w;
    logic [7:0] cmd, len;

    repeat (3) @(negedge bus_clk);
    chk("rst_cfg_wr_en", {31'h0, cfg_wr_en}, 32'h0);
    chk("rst_cfg_addr", {24'h0, cfg_addr}, 32'h0);
    chk("rst_cfg_wr_data", cfg_wr_data, 32'h0);
    chk("rst_pulses", {29'h0, daq_start, daq_reset, daq_close}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_counters", {frame_ok_cnt | frame_err_cnt | hdr_err_cnt, 16'h0}, 32'h0);
    reset_n = 1'b1;
    host_open = 1'b1;
    @(negedge bus_clk);

    // Two-word write frame
    bq = '{32'hF0010210, 32'h11111111, 32'h22222222, 32'hAA323123};
    send(0, "write");
    chk("write_ok_is_1", {16'h0, frame_ok_cnt}, 32'd1);

    // Start / reset / close
    for (int k = 2; k <= 4; k++) begin
      cmd = 8'(k);
      bq = '{{8'hF0, cmd, 16'h0000}, {8'hAA, cmd, 16'h0000}};
      send(0, "pulse");
    end

    // Bad checksum followed by a good frame
    bq = '{32'hF0010210, 32'h11111111, 32'h22222222, 32'hAA323124,
           32'hF0010210, 32'h11111111, 32'h22222222, 32'hAA323123};
    send(0, "badchk");
    chk("badchk_err_is_1", {16'h0, frame_err_cnt}, 32'd1);

    // Garbage then a start frame
    bq = '{32'h12345678, 32'hDEADBEEF, 32'hF0020000, 32'hAA020000};
    send(0, "garbage");
    chk("garbage_hdr_is_2", {16'h0, hdr_err_cnt}, 32'd2);

    // Address wrap
    add_frame(8'h01, 8'd3, 8'hFE, 1'b0);
    send(0, "wrap");

    // Full-length frame under random stalls, then an oversize header
    add_frame(8'h01, 8'd16, 8'h40, 1'b0);
    send(50, "stall16");
    bq = '{32'hF0011100};
    send(0, "len17");
    chk("len17_hdr_is_3", {16'h0, hdr_err_cnt}, 32'd3);

    // Abort after header plus one payload
    stall_pct = 0;
    fq.push_back(32'hF0010410);
    fq.push_back(32'h12345678);
    g_idx += 2;
    n = 0;
    while (fq.size() != 0 && n < 100) begin
      @(posedge bus_clk);
      n++;
    end
    chk("abort_drain", fq.size(), 32'h0);
    @(negedge bus_clk);
    chk("abort_busy_mid", {31'h0, busy}, 32'h1);
    host_open = 1'b0;
    @(negedge bus_clk);
    chk("abort_busy_after", {31'h0, busy}, 32'h0);
    host_open = 1'b1;
    repeat (4) @(negedge bus_clk);
    chk("abort_err_cnt", {16'h0, frame_err_cnt}, m_err);

    // Randomized batches
    for (int r = 0; r < 25; r++) begin
      nitems = $urandom_range(1, 4);
      for (int it = 0; it < nitems; it++) begin
        sel = $urandom_range(0, 9);
        if (sel < 2) begin
          w = $urandom;
          if (w[31:24] == 8'hF0 && w[15:8] <= 8'd16) w[15:8] = 8'd200;
          bq.push_back(w);
        end else begin
          c = $urandom_range(0, 7);
          cmd = (c == 0) ? 8'h00 : (c <= 3) ? 8'h01 : 8'(c - 2);
          if (cmd == 8'h01) len = 8'($urandom_range(0, 16));
          else len = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
          add_frame(cmd, len, 8'($urandom), $urandom_range(0, 4) == 0);
        end
      end
      send($urandom_range(0, 60), "random");
    end

    // Reset in the middle of a commit
    add_frame(8'h01, 8'd8, 8'h20, 1'b0);
    stall_pct = 0;
    model_batch(g_idx);
    g_idx += bq.size();
    foreach (bq[k]) fq.push_back(bq[k]);
    bq.delete();
    n = 0;
    while (exp_q.size() > 5 && n < 200) begin
      @(negedge bus_clk);
      n++;
    end
    chk("midcommit_reached", {31'h0, (n < 200)}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midcommit_wr_en", {31'h0, cfg_wr_en}, 32'h0);
    chk("midcommit_busy", {31'h0, busy}, 32'h0);
    chk("midcommit_ok_cnt", {16'h0, frame_ok_cnt}, 32'h0);
    exp_q.delete();
    fq.delete();
    m_ok = 0; m_err = 0; m_hdr = 0;
    @(negedge bus_clk);
    chk("midcommit_wr_en_held", {31'h0, cfg_wr_en}, 32'h0);
    reset_n = 1'b1;
    @(negedge bus_clk);
    bq = '{32'hF0040000, 32'hAA040000};
    send(0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
